// File: rtl/neuron_pkg.sv
// Shared sizing, FSM encoding and saturation limits for the neuron MAC datapath.
package neuron_pkg;

    localparam int DATA_W    = 16;
    localparam int FRAC_BITS = 8;
    localparam int ACC_W     = 40;
    localparam int N_INPUTS  = 28;
    localparam int ADDR_W    = 5;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

endpackage

// File: rtl/neuron_round_sat.sv
// Bias add, round-half-up, Q8.8 rescale and saturation of the accumulated dot product.
// Defining NEURON_RELU_EN clamps negative results to zero after saturation.
module neuron_round_sat
    import neuron_pkg::*;
(
    input  logic signed [ACC_W-1:0]  acc,
    input  logic signed [DATA_W-1:0] bias,
    output logic signed [DATA_W-1:0] y
);

    localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) << (FRAC_BITS - 1);
    localparam logic signed [ACC_W-1:0] MAX_EXT  = {{(ACC_W-DATA_W){SAT_MAX[DATA_W-1]}}, SAT_MAX};
    localparam logic signed [ACC_W-1:0] MIN_EXT  = {{(ACC_W-DATA_W){SAT_MIN[DATA_W-1]}}, SAT_MIN};

    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] shifted;

    assign bias_ext = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias};

    always_comb begin
        sum     = acc + (bias_ext <<< FRAC_BITS) + RND_HALF;
        shifted = sum >>> FRAC_BITS;
        if (shifted > MAX_EXT) begin
            y = SAT_MAX;
        end else if (shifted < MIN_EXT) begin
            y = SAT_MIN;
        end else begin
            y = shifted[DATA_W-1:0];
        end
`ifdef NEURON_RELU_EN
        if (y[DATA_W-1]) begin
            y = '0;
        end
`endif
    end

endmodule

// File: rtl/neuron_mac_unit.sv
// Hidden-layer neuron: sweeps weight/activation BRAMs, multiply-accumulates, emits one Q8.8 result.
// The ReLU option (NEURON_RELU_EN) lives in neuron_round_sat and does not change timing.
//   state | meaning
//   IDLE  | waiting for START
//   RUN   | issuing BRAM addresses 0..N_INPUTS-1
//   DRAIN | two cycles letting the product/accumulate pipeline empty
//   OUT   | Y_VALID cycle; START here begins the next evaluation
module neuron_mac_unit
    import neuron_pkg::*;
(
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     START,
    input  logic signed [DATA_W-1:0] BIAS,
    output logic [ADDR_W-1:0]        W_ADDR,
    output logic                     W_EN,
    output logic                     W_WE,
    input  logic signed [DATA_W-1:0] W_DO,
    output logic [ADDR_W-1:0]        X_ADDR,
    output logic                     X_EN,
    input  logic signed [DATA_W-1:0] X_DO,
    output logic                     BUSY,
    output logic signed [DATA_W-1:0] Y_OUT,
    output logic                     Y_VALID
);

    logic [1:0]                state_q, state_d;
    logic [ADDR_W-1:0]         cnt_q, cnt_d;
    logic                      drain_q, drain_d;
    logic                      en_q, en_d;
    logic signed [DATA_W-1:0]  bias_q, bias_d;
    logic signed [2*DATA_W-1:0] prod_q, prod_d;
    logic                      pv_q, pv_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [DATA_W-1:0]  y_q, y_d;
    logic                      yv_q, yv_d;

    logic signed [2*DATA_W-1:0] w_ext, x_ext;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [DATA_W-1:0]   rs_y;

    assign w_ext    = {{DATA_W{W_DO[DATA_W-1]}}, W_DO};
    assign x_ext    = {{DATA_W{X_DO[DATA_W-1]}}, X_DO};
    assign prod_ext = {{(ACC_W-2*DATA_W){prod_q[2*DATA_W-1]}}, prod_q};

    neuron_round_sat u_round_sat (
        .acc  (acc_q),
        .bias (bias_q),
        .y    (rs_y)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        en_d    = en_q;
        bias_d  = bias_q;
        y_d     = y_q;
        yv_d    = 1'b0;
        // pv tracks whether the product register holds a freshly read pair
        prod_d  = w_ext * x_ext;
        pv_d    = en_q;
        acc_d   = pv_q ? (acc_q + prod_ext) : acc_q;

        case (state_q)
            ST_IDLE, ST_OUT: begin
                if (START) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    acc_d   = '0;
                    bias_d  = BIAS;
                    en_d    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_q == ADDR_W'(N_INPUTS - 1)) begin
                    state_d = ST_DRAIN;
                    en_d    = 1'b0;
                    drain_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == 1'b0) begin
                    state_d = ST_OUT;
                    y_d     = rs_y;
                    yv_d    = 1'b1;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            drain_q <= 1'b0;
            en_q    <= 1'b0;
            bias_q  <= '0;
            prod_q  <= '0;
            pv_q    <= 1'b0;
            acc_q   <= '0;
            y_q     <= '0;
            yv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            en_q    <= en_d;
            bias_q  <= bias_d;
            prod_q  <= prod_d;
            pv_q    <= pv_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            yv_q    <= yv_d;
        end
    end

    assign W_ADDR  = cnt_q;
    assign X_ADDR  = cnt_q;
    assign W_EN    = en_q;
    assign X_EN    = en_q;
    assign W_WE    = 1'b0;
    assign BUSY    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign Y_OUT   = y_q;
    assign Y_VALID = yv_q;

endmodule

// File: tb/tb_neuron_mac_unit.sv
// Self-checking bench for neuron_mac_unit with negedge-read BRAM models and a plain-arithmetic reference.
module tb_neuron_mac_unit;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        START;
    logic [15:0] BIAS;
    logic [4:0]  W_ADDR, X_ADDR;
    logic        W_EN, W_WE, X_EN;
    logic [15:0] w_do, x_do;
    logic        BUSY;
    logic [15:0] Y_OUT;
    logic        Y_VALID;

    always #5 CLK = ~CLK;

    neuron_mac_unit dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .START   (START),
        .BIAS    (BIAS),
        .W_ADDR  (W_ADDR),
        .W_EN    (W_EN),
        .W_WE    (W_WE),
        .W_DO    (w_do),
        .X_ADDR  (X_ADDR),
        .X_EN    (X_EN),
        .X_DO    (x_do),
        .BUSY    (BUSY),
        .Y_OUT   (Y_OUT),
        .Y_VALID (Y_VALID)
    );

    logic [15:0] wmem [0:31];
    logic [15:0] xmem [0:31];
    int addr_hits [0:31];
    int yv_count    = 0;
    int port_mismatch = 0;
    int n_cmp = 0;
    int n_bad = 0;

    initial begin
        w_do = '0;
        x_do = '0;
    end

    // Negedge-read BRAMs plus bus monitors
    always @(negedge CLK) begin
        if (W_EN) begin
            w_do = wmem[W_ADDR];
            addr_hits[W_ADDR] = addr_hits[W_ADDR] + 1;
        end
        if (X_EN) x_do = xmem[X_ADDR];
        if (X_ADDR !== W_ADDR || X_EN !== W_EN || W_WE !== 1'b0) port_mismatch = port_mismatch + 1;
        if (Y_VALID) yv_count = yv_count + 1;
    end

    typedef struct {
        logic [15:0] w;
        logic [15:0] x;
        logic [15:0] bias;
        bit          first_only;
        logic [15:0] exp_lin;
        logic [15:0] exp_relu;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load(input logic [15:0] w, input logic [15:0] x, input bit first_only);
        for (int k = 0; k < 32; k++) begin
            wmem[k] = (k >= 28 || (first_only && k != 0)) ? 16'h0 : w;
            xmem[k] = (k >= 28 || (first_only && k != 0)) ? 16'h0 : x;
        end
    endtask

    function automatic logic [15:0] model_y(input logic [15:0] b);
        longint s;
        s = 0;
        for (int k = 0; k < 28; k++)
            s += longint'($signed(wmem[k])) * longint'($signed(xmem[k]));
        s += longint'($signed(b)) * 256 + 128;
        s = s >>> 8;
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
`ifdef NEURON_RELU_EN
        if (s < 0) s = 0;
`endif
        return s[15:0];
    endfunction

    task automatic clear_hits();
        for (int k = 0; k < 32; k++) addr_hits[k] = 0;
    endtask

    task automatic run_eval(input logic [15:0] b, output logic [15:0] y, output int lat);
        @(negedge CLK);
        BIAS  = b;
        START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        check("busy_after_accept", {31'd0, BUSY}, 32'd1);
        lat = 0;
        while (lat < 60) begin
            @(posedge CLK);
            #1;
            lat++;
            if (Y_VALID) break;
        end
        y = Y_OUT;
        check("busy_low_at_valid", {31'd0, BUSY}, 32'd0);
        @(posedge CLK);
        #1 check("y_valid_one_cycle", {31'd0, Y_VALID}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] y, y1, y2, b;
        int lat, base, v1, v2, idx, bad_addr;

        vecs[0] = '{16'h0100, 16'h0100, 16'h0000, 1'b0, 16'h1C00, 16'h1C00};
        vecs[1] = '{16'h7FFF, 16'h7FFF, 16'h0000, 1'b0, 16'h7FFF, 16'h7FFF};
        vecs[2] = '{16'h8000, 16'h7FFF, 16'h0000, 1'b0, 16'h8000, 16'h0000};
        vecs[3] = '{16'hFF00, 16'h0100, 16'h0200, 1'b0, 16'hE600, 16'h0000};
        vecs[4] = '{16'h0001, 16'h0080, 16'h0000, 1'b1, 16'h0001, 16'h0001};
        vecs[5] = '{16'h0001, 16'h007F, 16'h0000, 1'b1, 16'h0000, 16'h0000};
        vecs[6] = '{16'h0000, 16'h0000, 16'h7FFF, 1'b0, 16'h7FFF, 16'h7FFF};
        vecs[7] = '{16'h0000, 16'h0000, 16'h8000, 1'b0, 16'h8000, 16'h0000};

        clear_hits();
        load(16'h0, 16'h0, 1'b0);
        RST_N = 1'b0;
        START = 1'b0;
        BIAS  = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_w_addr", {27'd0, W_ADDR}, 32'd0);
        check("rst_x_addr", {27'd0, X_ADDR}, 32'd0);
        check("rst_w_en", {31'd0, W_EN}, 32'd0);
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        check("rst_y_out", {16'd0, Y_OUT}, 32'd0);
        check("rst_y_valid", {31'd0, Y_VALID}, 32'd0);
        @(negedge CLK) RST_N = 1'b1;

        foreach (vecs[i]) begin
            load(vecs[i].w, vecs[i].x, vecs[i].first_only);
            run_eval(vecs[i].bias, y, lat);
            check($sformatf("vec%0d_latency", i), lat, 32'd30);
`ifdef NEURON_RELU_EN
            check($sformatf("vec%0d_y", i), {16'd0, y}, {16'd0, vecs[i].exp_relu});
`else
            check($sformatf("vec%0d_y", i), {16'd0, y}, {16'd0, vecs[i].exp_lin});
`endif
        end

        for (int t = 0; t < 10; t++) begin
            int v;
            bit wide;
            wide = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < 32; k++) begin
                if (k >= 28) begin
                    wmem[k] = 16'h0;
                    xmem[k] = 16'h0;
                end else if (wide) begin
                    wmem[k] = 16'($urandom);
                    xmem[k] = 16'($urandom);
                end else begin
                    v = int'($urandom_range(0, 511)) - 256;
                    wmem[k] = v[15:0];
                    v = int'($urandom_range(0, 511)) - 256;
                    xmem[k] = v[15:0];
                end
            end
            v = int'($urandom_range(0, 8191)) - 4096;
            b = v[15:0];
            run_eval(b, y, lat);
            check($sformatf("rand%0d_y", t), {16'd0, y}, {16'd0, model_y(b)});
        end

        // START pulsed mid-run must be ignored
        load(16'h0100, 16'h0100, 1'b0);
        clear_hits();
        base = yv_count;
        v1 = 0;
        @(negedge CLK);
        BIAS = 16'h0;
        START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            @(posedge CLK);
            #1;
            if (c == 10) START = 1'b1;
            if (c == 11) START = 1'b0;
            if (Y_VALID && v1 == 0) begin
                v1 = c;
                y1 = Y_OUT;
            end
        end
        check("ignore_start_latency", v1, 32'd30);
        check("ignore_start_y", {16'd0, y1}, 32'h1C00);
        check("ignore_start_single_valid", yv_count - base, 32'd1);
        bad_addr = 0;
        for (int k = 0; k < 32; k++)
            if (addr_hits[k] != ((k < 28) ? 1 : 0)) bad_addr++;
        check("addr_each_once", bad_addr, 32'd0);

        // START held through OUT gives back-to-back evaluations
        v1 = 0;
        v2 = 0;
        idx = 0;
        @(negedge CLK);
        START = 1'b1;
        @(posedge CLK);
        while (idx < 100 && v2 == 0) begin
            @(posedge CLK);
            #1;
            idx++;
            if (Y_VALID) begin
                if (v1 == 0) begin
                    v1 = idx;
                    y1 = Y_OUT;
                end else begin
                    v2 = idx;
                    y2 = Y_OUT;
                    START = 1'b0;
                end
            end
        end
        START = 1'b0;
        check("b2b_first_latency", v1, 32'd30);
        check("b2b_second_latency", v2, 32'd61);
        check("b2b_first_y", {16'd0, y1}, 32'h1C00);
        check("b2b_second_y", {16'd0, y2}, 32'h1C00);
        repeat (3) @(posedge CLK);
        #1 check("b2b_idle_after", {31'd0, BUSY}, 32'd0);

        // Reset mid-run aborts without a result
        @(negedge CLK);
        START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        repeat (15) @(posedge CLK);
        #1 RST_N = 1'b0;
        base = yv_count;
        @(posedge CLK);
        #1;
        check("abort_busy", {31'd0, BUSY}, 32'd0);
        check("abort_w_en", {31'd0, W_EN}, 32'd0);
        check("abort_y_out", {16'd0, Y_OUT}, 32'd0);
        @(negedge CLK) RST_N = 1'b1;
        repeat (40) @(posedge CLK);
        #1 check("abort_no_valid", yv_count - base, 32'd0);
        run_eval(16'h0, y, lat);
        check("after_abort_latency", lat, 32'd30);
        check("after_abort_y", {16'd0, y}, 32'h1C00);

        check("port_mirror", port_mismatch, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
